// File: rtl/irq_ctrl8.sv
// Eight-source interrupt controller for the J1 core: synchronised edge/level capture,
// pending/mask/mode registers on the IO bus, fixed-priority one-hot request, vector-snoop acknowledge.
module irq_ctrl8 #(
  parameter logic [15:0] BASE     = 16'h0100,
  parameter logic [12:0] VEC_BASE = 13'h1DF8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [7:0]  irq_src,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [12:0] code_addr,
  output logic [7:0]  int_rqst
);

  localparam logic [15:0] ADDR_PEND   = BASE;
  localparam logic [15:0] ADDR_SWSET  = BASE + 16'd2;
  localparam logic [15:0] ADDR_MASK   = BASE + 16'd4;
  localparam logic [15:0] ADDR_MODE   = BASE + 16'd6;
  localparam logic [15:0] ADDR_STATUS = BASE + 16'd8;

  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;
  logic [7:0] s3_q, s3_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic [2:0] last_vec_q, last_vec_d;
  logic       last_valid_q, last_valid_d;

  logic       sel_pend, sel_swset, sel_mask, sel_mode, sel_status;
  logic       wr_pend, wr_swset, wr_mask, wr_mode, wr_status;
  logic [7:0] rise;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_any;
  logic       ack_hit;
  logic [7:0] ack_mask;
  logic [7:0] sw_set, w1c, mode_on;
  logic [7:0] edge_set, edge_clr;
  logic       unused_wdata_hi;

  assign unused_wdata_hi = ^io_wdata[15:8];

  always_comb begin
    sel_pend   = (io_addr == ADDR_PEND);
    sel_swset  = (io_addr == ADDR_SWSET);
    sel_mask   = (io_addr == ADDR_MASK);
    sel_mode   = (io_addr == ADDR_MODE);
    sel_status = (io_addr == ADDR_STATUS);
    wr_pend    = io_wr & sel_pend;
    wr_swset   = io_wr & sel_swset;
    wr_mask    = io_wr & sel_mask;
    wr_mode    = io_wr & sel_mode;
    wr_status  = io_wr & sel_status;
  end

  // Fixed priority: the highest-numbered requesting source wins.
  always_comb begin
    req       = pending_q & mask_q;
    grant_idx = 3'd0;
    grant_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        grant_idx = 3'(i);
        grant_any = 1'b1;
      end
    end
    grant = grant_any ? (8'd1 << grant_idx) : 8'd0;
  end

  assign int_rqst = grant;

  // Only the currently granted vector is compared, so a stale call to another vector is ignored.
  always_comb begin
    ack_hit  = grant_any && (code_addr == (VEC_BASE + {10'd0, grant_idx}));
    ack_mask = ack_hit ? grant : 8'h00;
  end

  always_comb begin
    s1_d = irq_src;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;
  end

  // Edge bits: set beats clear. Level bits: mirror s2. A 0->1 mode write wipes the bit.
  always_comb begin
    sw_set    = wr_swset ? io_wdata[7:0] : 8'h00;
    w1c       = wr_pend  ? io_wdata[7:0] : 8'h00;
    mode_on   = wr_mode  ? (io_wdata[7:0] & ~mode_q) : 8'h00;
    edge_set  = rise | sw_set;
    edge_clr  = w1c | ack_mask;
    pending_d = ~mode_on & ((mode_q & (edge_set | (pending_q & ~edge_clr)))
                            | (~mode_q & s2_q));
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_mask) mask_d = io_wdata[7:0];
    if (wr_mode) mode_d = io_wdata[7:0];
  end

  always_comb begin
    last_vec_d   = last_vec_q;
    last_valid_d = last_valid_q;
    if (wr_status) last_valid_d = 1'b0;
    if (ack_hit) begin
      last_valid_d = 1'b1;
      last_vec_d   = grant_idx;
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (io_rd && resetq) begin
      if (sel_pend)        io_rdata = {8'h00, pending_q};
      else if (sel_mask)   io_rdata = {8'h00, mask_q};
      else if (sel_mode)   io_rdata = {8'h00, mode_q};
      else if (sel_status) io_rdata = {s2_q, 4'b0000, last_valid_q, last_vec_q};
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1_q         <= 8'h00;
      s2_q         <= 8'h00;
      s3_q         <= 8'h00;
      pending_q    <= 8'h00;
      mask_q       <= 8'h00;
      mode_q       <= 8'hFF;
      last_vec_q   <= 3'd0;
      last_valid_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      last_vec_q   <= last_vec_d;
      last_valid_q <= last_valid_d;
    end
  end

endmodule

// File: doc/irq_ctrl8.md
# irq_ctrl8

Eight-source interrupt controller between peripheral interrupt lines and the J1 core's `int_rqst[7:0]` input. It provides:
- synchronisation, per-source edge or level capture, pending and mask registers, and a priority-resolved one-hot request;
- automatic acknowledge by snooping the core's `code_addr` for the vector call.

Software configures it through the J1 IO bus (`io_rd`/`io_wr`, address = `mem_addr`, write data = `dout`, read data OR-muxed into `io_din`).

## Interface
- `BASE`, default 16'h0100: IO base address; registers at `BASE`+0,2,4,6,8.
- `VEC_BASE`, default 13'h1DF8: code word address of vector 0; vector n = `VEC_BASE`+n.
- `clk`  in  1  system clock; all state changes on rising edge.
- `resetq`  in  1  reset, asynchronous, active-low.
- `irq_src`  in  8  raw peripheral requests, active-high, asynchronous to `clk`.
- `io_rd`  in  1  core IO read strobe.
- `io_wr`  in  1  core IO write strobe.
- `io_addr`  in  16  core IO address (`mem_addr`).
- `io_wdata`  in  16  core write data (`dout`).
- `io_rdata`  out  16  read data, 0 when not selected.
- `code_addr`  in  13  core next-PC (`pcN`).
- `int_rqst`  out  8  to core; at most one bit set, highest-priority pending & enabled source.

## Operation
- **Synchronisation.** `irq_src` passes through two flops (s1, s2). A third flop s3 holds the previous s2. Edge detect: `rise[n]` = s2[n] & ~s3[n].
- **Register map** (16-bit, byte offsets; unused bits read 0).
  - +0 `PEND`: read pending[7:0]. Write-1-to-clear; edge-mode bits only.
  - +2 `SWSET`: write-1-to-set pending; edge-mode bits only. Reads 0.
  - +4 `MASK`: read/write enable[7:0]. Reset 8'h00.
  - +6 `MODE`: read/write. 1 = edge, 0 = level. Reset 8'hFF.
  - +8 `STATUS`: read {s2[7:0], 4'b0, last_valid, last_vec[2:0]}. Any write clears `last_valid`.
- **Edge-mode pending[n]:**
  - Set by `rise[n]` or `SWSET` bit n.
  - Cleared by `PEND` W1C or by acknowledge.
  - Set has priority over clear in the same cycle.
- **Level-mode pending[n]:** equals s2[n] every cycle. W1C, `SWSET` and acknowledge have no effect.
- **Mode change.** Changing `MODE` bit n from 0 to 1 clears pending[n] on that write edge; it is then set only by subsequent edges.
- **Request.** req = pending & `MASK`. `int_rqst` = one-hot of the highest set bit of req (bit 7 highest), else 0. Combinational from registers only, so it is glitch-free.
- **Acknowledge.**
  - Condition: `code_addr` == `VEC_BASE`+n and `int_rqst`[n] = 1 in the same cycle. `code_addr` is compared only against the currently granted n.
  - On that clock edge: edge-mode pending[n] clears unless `rise[n]` coincides; `last_vec` <= n; `last_valid` <= 1.
  - A `code_addr` match with `int_rqst`[n] = 0 is ignored.
- **IO access.**
  - Writes take effect on the rising edge where `io_wr`=1 and `io_addr` matches.
  - `io_rdata` is combinational: register value when `io_rd`=1 and address matches, else 16'h0000.
  - Non-matching addresses are ignored.

## Timing
- **Reset values.** All outputs low while `resetq`=0. s1/s2/s3, pending, `MASK` = 0; `MODE` = 8'hFF; `last_vec` = 0; `last_valid` = 0. `int_rqst` = 0 and `io_rdata` = 0.
- **Reset mid-operation.** Reset clears pending immediately (asynchronously). No acknowledge is generated.
- **Source-to-request latency.** `irq_src` rising meeting setup before edge k gives s1 at k, s2 at k+1, pending at k+2. `int_rqst` is valid after edge k+2, if enabled and highest.
- **Level-mode latency.** pending follows s2 with 1 cycle latency (valid after edge k+2). Deassert latency is the same.
- **Acknowledge latency.** `int_rqst`[n] drops after the acknowledge edge. The next-priority request appears in the same cycle if pending.
- **Mask latency.** `MASK` write: `int_rqst` updates in the cycle after the write edge.
- **Minimum pulse.** Edge-mode source pulse must be at least 2 clk periods wide to be captured. Back-to-back edges closer than 3 cycles are not distinguished; one pending bit, no counting.

## Test plan
- **Edge capture.** Reset; `MODE`=FF, `MASK`=01; pulse `irq_src`[0] 3 cycles. Expected: `int_rqst`=01 from 3rd edge. Drive `code_addr`=1DF8 one cycle. Expected: `int_rqst`=00, `STATUS`=0x0008 | s2<<8.
- **Priority.** `MASK`=FF; raise `irq_src`[2] and [6] together. Expected: `int_rqst`=40. After ack at 1DFE: `int_rqst`=04. After ack at 1DFA: `int_rqst`=00, `last_vec`=2.
- **Level mode.** `MODE`=00, `MASK`=80; hold `irq_src`[7] high. Expected: `int_rqst`=80 persists through `code_addr`=1DFF and `PEND` W1C=FF. Lower source: `int_rqst`=00 three edges later.
- **Simultaneous set and clear.** Edge mode; W1C `PEND`=02 on the same edge as `rise`[1]. Expected: pending[1] stays 1. `SWSET`=10 with `MASK`=00. Expected: `PEND` reads 0x0010, `int_rqst`=00.
- **Bus and reset.** Reads at `BASE`+4/+6 after reset. Expected: 0x0000 and 0x00FF. Read at `BASE`+10: 0. Assert `resetq` low with pending=FF. Expected: `PEND`=0 and `int_rqst`=0 immediately.
